// File: rtl/audipus_pkg.sv
// rtl/audipus_pkg.sv - shared constants and state encoding for the codec control-bus master
package audipus_pkg;

  localparam int   CODEC_FRAME_W = 16;
  localparam logic DEV_PCM9211   = 1'b0;
  localparam logic DEV_PCM1792   = 1'b1;
  localparam logic SPI_RW_READ   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LO,
    ST_HI,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_half_tick.sv
// rtl/spi_half_tick.sv - pulses once every HALF_PERIOD clk cycles, restartable
module spi_half_tick #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(HALF_PERIOD - 1);

  logic [7:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/codec_spi_master.sv
// rtl/codec_spi_master.sv - SPI initiator issuing one 16-bit R/W frame to PCM9211 or PCM1792
module codec_spi_master
  import audipus_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic       dev_sel,
  input  logic [6:0] addr,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       spi_cs_pcm9211_n,
  output logic       spi_cs_pcm1792_n
);

  spi_state_e state, state_d;
  logic [4:0] bit_cnt, bit_cnt_d;
  logic [CODEC_FRAME_W-2:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d, rd_data_d;
  logic rw_q, rw_d, dev_q, dev_d, gap_q, gap_d;
  logic mosi_d, done_d, accept, tick, miso_q, frame_act;

  spi_half_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      bit_cnt          <= '0;
      tx_q             <= '0;
      rx_q             <= '0;
      rw_q             <= 1'b0;
      dev_q            <= 1'b0;
      gap_q            <= 1'b0;
      miso_q           <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      rd_data          <= '0;
      spi_sclk         <= 1'b1;
      spi_mosi         <= 1'b0;
      spi_cs_pcm9211_n <= 1'b1;
      spi_cs_pcm1792_n <= 1'b1;
    end else begin
      state            <= state_d;
      bit_cnt          <= bit_cnt_d;
      tx_q             <= tx_d;
      rx_q             <= rx_d;
      rw_q             <= rw_d;
      dev_q            <= dev_d;
      gap_q            <= gap_d;
      miso_q           <= spi_miso;
      busy             <= (state_d != ST_IDLE);
      done             <= done_d;
      rd_data          <= rd_data_d;
      spi_sclk         <= (state_d != ST_LO);
      spi_mosi         <= mosi_d;
      // Outputs follow the next state so each pin changes on the same edge as the state.
      spi_cs_pcm9211_n <= !(frame_act && (dev_d == DEV_PCM9211));
      spi_cs_pcm1792_n <= !(frame_act && (dev_d == DEV_PCM1792));
    end
  end

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    gap_d     = gap_q;
    mosi_d    = spi_mosi;
    done_d    = 1'b0;
    rd_data_d = rd_data;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_d   = ST_SETUP;
          rw_d      = rw;
          dev_d     = dev_sel;
          bit_cnt_d = '0;
          mosi_d    = rw;
          tx_d      = {addr, (rw == SPI_RW_READ) ? 8'h00 : wr_data};
        end
      end
      ST_SETUP: begin
        if (tick) state_d = ST_LO;
      end
      ST_LO: begin
        if (tick) begin
          state_d   = ST_HI;
          bit_cnt_d = bit_cnt + 5'd1;
          rx_d      = {rx_q[6:0], miso_q};
        end
      end
      ST_HI: begin
        if (tick) begin
          if (bit_cnt == 5'(CODEC_FRAME_W)) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LO;
            mosi_d  = tx_q[CODEC_FRAME_W-2];
            tx_d    = {tx_q[CODEC_FRAME_W-3:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_GAP;
          gap_d   = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          if (rw_q == SPI_RW_READ) rd_data_d = rx_q;
        end
      end
      ST_GAP: begin
        // The gap spans two half-periods; gap_q marks the second one.
        if (tick) begin
          if (gap_q) state_d = ST_IDLE;
          else       gap_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_act = 1'b0;
    case (state_d)
      ST_SETUP, ST_LO, ST_HI, ST_HOLD: frame_act = 1'b1;
      default:                         frame_act = 1'b0;
    endcase
  end

endmodule
